// File: rtl/rvcore_insn_line_cache.sv
// Direct-mapped 128-bit instruction line cache between fetch and memory.
// Blocking miss/refill FSM with snoop invalidate, flush and fill poisoning.
module rvcore_insn_line_cache #(
  parameter int unsigned LINES   = 16,
  parameter bit          ENABLE  = 1'b1,
  parameter int unsigned MHARTID = 0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         core_req,
  input  logic [31:0]  core_addr,
  output logic         core_valid,
  output logic [127:0] core_rdata,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ack,
  input  logic [127:0] mem_rdata,
  input  logic         inv_valid,
  input  logic [31:0]  inv_addr,
  input  logic         flush,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 28 - IDX_W;
  localparam logic [31:0] HART_ID = 32'(MHARTID);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MISS = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d, valid_clr;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [127:0]     data_q [LINES];

  logic             core_valid_q, core_valid_d;
  logic [127:0]     core_rdata_q, core_rdata_d;
  logic             mem_req_q, mem_req_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      hit_cnt_q, hit_cnt_d;
  logic [31:0]      miss_cnt_q, miss_cnt_d;
  logic             poison_q, poison_d;

  logic [IDX_W-1:0] req_idx, inv_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, inv_tag, fill_tag;
  logic             inv_hit, lookup_hit, poison_now, fill_we;
  logic             unused_bits;

  assign req_idx  = core_addr[4 +: IDX_W];
  assign req_tag  = core_addr[31 -: TAG_W];
  assign inv_idx  = inv_addr[4 +: IDX_W];
  assign inv_tag  = inv_addr[31 -: TAG_W];
  assign fill_idx = mem_addr_q[4 +: IDX_W];
  assign fill_tag = mem_addr_q[31 -: TAG_W];

  assign unused_bits = ^{core_addr[3:0], inv_addr[3:0], HART_ID};

  assign inv_hit = inv_valid && valid_q[inv_idx]
                && (tag_q[inv_idx] == inv_tag);

  assign poison_now = flush
    || (inv_valid && (inv_addr[31:4] == mem_addr_q[31:4]));

  assign fill_we = (state_q == S_MISS) && mem_ack && ENABLE
                && !poison_q && !poison_now;

  // Invalidate/flush first so a same-cycle lookup sees the cleared state
  always_comb begin
    valid_clr = valid_q;
    if (inv_hit) valid_clr[inv_idx] = 1'b0;
    if (flush) valid_clr = '0;
    valid_d = valid_clr;
    if (fill_we) valid_d[fill_idx] = 1'b1;
  end

  assign lookup_hit = ENABLE && valid_clr[req_idx]
                   && (tag_q[req_idx] == req_tag);

  // Lookup, miss handshake and counter next-state
  always_comb begin
    state_d      = state_q;
    core_valid_d = 1'b0;
    core_rdata_d = core_rdata_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    poison_d     = poison_q;
    unique case (state_q)
      S_IDLE: begin
        poison_d = 1'b0;
        if (core_req) begin
          if (lookup_hit) begin
            core_valid_d = 1'b1;
            core_rdata_d = data_q[req_idx];
            hit_cnt_d    = hit_cnt_q + 32'd1;
          end else begin
            state_d    = S_MISS;
            mem_req_d  = 1'b1;
            mem_addr_d = {core_addr[31:4], 4'h0};
            miss_cnt_d = miss_cnt_q + 32'd1;
          end
        end
      end
      S_MISS: begin
        poison_d = poison_q | poison_now;
        if (mem_ack) begin
          core_valid_d = 1'b1;
          core_rdata_d = mem_rdata;
          mem_req_d    = 1'b0;
          poison_d     = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, outputs and valid bits
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      core_valid_q <= 1'b0;
      core_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      poison_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      core_valid_q <= core_valid_d;
      core_rdata_q <= core_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      poison_q     <= poison_d;
    end
  end

  // Tag and data storage, written only by a clean refill
  always_ff @(posedge CLK) begin
    if (!RST && fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_rdata;
    end
  end

  assign core_valid = core_valid_q;
  assign core_rdata = core_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_rvcore_insn_line_cache.sv
// Bench for rvcore_insn_line_cache: vector table plus corner sequences.
// Returned lines are checked against a queue of expected data.
module tb_rvcore_insn_line_cache;

  logic         CLK;
  logic         RST;
  logic         core_req;
  logic [31:0]  core_addr;
  logic         core_valid;
  logic [127:0] core_rdata;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [127:0] mem_rdata;
  logic         inv_valid;
  logic [31:0]  inv_addr;
  logic         flush;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  logic         b_req;
  logic [31:0]  b_addr;
  logic         b_valid;
  logic [127:0] b_rdata;
  logic         b_mem_req;
  logic [31:0]  b_mem_addr;
  logic         b_ack;
  logic [127:0] b_mrdata;
  logic [31:0]  b_hit;
  logic [31:0]  b_miss;

  rvcore_insn_line_cache #(
    .LINES(16), .ENABLE(1'b1), .MHARTID(0)
  ) u_dut (
    .CLK(CLK), .RST(RST),
    .core_req(core_req), .core_addr(core_addr),
    .core_valid(core_valid), .core_rdata(core_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inv_valid(inv_valid), .inv_addr(inv_addr),
    .flush(flush),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  rvcore_insn_line_cache #(
    .LINES(16), .ENABLE(1'b0), .MHARTID(1)
  ) u_unc (
    .CLK(CLK), .RST(RST),
    .core_req(b_req), .core_addr(b_addr),
    .core_valid(b_valid), .core_rdata(b_rdata),
    .mem_req(b_mem_req), .mem_addr(b_mem_addr),
    .mem_ack(b_ack), .mem_rdata(b_mrdata),
    .inv_valid(1'b0), .inv_addr(32'h0),
    .flush(1'b0),
    .hit_cnt(b_hit), .miss_cnt(b_miss)
  );

  typedef struct {
    logic [31:0]  addr;
    int           dly;
    logic [127:0] data;
    bit           hit;
    bit           flush_ack;
    bit           inv_pre;
    bit           inv_same;
    logic [31:0]  inv_a;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int m_hit  = 0;
  int m_miss = 0;
  logic [127:0] exp_q [$];
  logic [127:0] exp_d;
  vec_t tbl [16];

  localparam logic [127:0] D0 = 128'h0123456789ABCDEF_0123456789ABCDEF;
  localparam logic [127:0] D1 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] D2 = 128'hA5A5A5A5_5A5A5A5A_DEADBEEF_CAFEF00D;
  localparam logic [127:0] D3 = 128'h00000000_00000000_00000000_00000003;
  localparam logic [127:0] D4 = 128'hFFFFFFFF_00000000_FFFFFFFF_00000004;
  localparam logic [127:0] D5 = 128'h13579BDF_2468ACE0_13579BDF_24680005;
  localparam logic [127:0] D6 = 128'h66666666_66666666_66666666_66666666;
  localparam logic [127:0] D7 = 128'h77777777_0000FFFF_77777777_0000FFFF;
  localparam logic [127:0] D8 = 128'h88888888_88888888_12345678_9ABCDEF0;
  localparam logic [127:0] D9 = 128'h99999999_FEDCBA98_76543210_99999999;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard: every core_valid pulse consumes one expected line
  always @(negedge CLK) begin
    if (core_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %h want none", core_rdata);
      end else begin
        exp_d = exp_q.pop_front();
        if (core_rdata !== exp_d) begin
          errors++;
          $display("FAIL sb_rdata: got %h want %h", core_rdata, exp_d);
        end
      end
    end
  end

  function automatic vec_t mk(input logic [31:0] a, input int d,
                              input logic [127:0] dt, input bit h,
                              input bit fa, input bit ip,
                              input bit is, input logic [31:0] ia);
    vec_t v;
    v.addr = a; v.dly = d; v.data = dt; v.hit = h;
    v.flush_ack = fa; v.inv_pre = ip; v.inv_same = is; v.inv_a = ia;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    if (v.inv_pre) begin
      inv_valid = 1'b1;
      inv_addr  = v.inv_a;
      step();
      inv_valid = 1'b0;
    end
    core_req  = 1'b1;
    core_addr = v.addr;
    if (v.inv_same) begin
      inv_valid = 1'b1;
      inv_addr  = v.inv_a;
    end
    exp_q.push_back(v.data);
    step();
    inv_valid = 1'b0;
    if (v.hit) begin
      m_hit++;
      chk("hit_valid", core_valid, 1'b1);
      chk("hit_no_memreq", mem_req, 1'b0);
      core_req = 1'b0;
    end else begin
      m_miss++;
      chk("miss_memreq", mem_req, 1'b1);
      chk("miss_addr", mem_addr, {v.addr[31:4], 4'h0});
      for (int i = 0; i < v.dly; i++) begin
        step();
        chk("wait_memreq", mem_req, 1'b1);
        chk("wait_novalid", core_valid, 1'b0);
      end
      mem_ack   = 1'b1;
      mem_rdata = v.data;
      flush     = v.flush_ack;
      step();
      mem_ack  = 1'b0;
      flush    = 1'b0;
      core_req = 1'b0;
      chk("fill_valid", core_valid, 1'b1);
      chk("fill_memreq_drop", mem_req, 1'b0);
    end
    chk("hit_cnt", hit_cnt, m_hit);
    chk("miss_cnt", miss_cnt, m_miss);
    step();
  endtask

  initial begin
    tbl[0]  = mk(32'h8000_0010, 3, D0, 0, 0, 0, 0, 32'h0);
    tbl[1]  = mk(32'h8000_0010, 0, D0, 1, 0, 0, 0, 32'h0);
    tbl[2]  = mk(32'h8000_0040, 1, D1, 0, 0, 0, 0, 32'h0);
    tbl[3]  = mk(32'h8000_0140, 0, D2, 0, 0, 0, 0, 32'h0);
    tbl[4]  = mk(32'h8000_0040, 2, D3, 0, 0, 0, 0, 32'h0);
    tbl[5]  = mk(32'h8000_0040, 0, D3, 1, 0, 0, 0, 32'h0);
    tbl[6]  = mk(32'h8000_0020, 1, D4, 0, 0, 0, 0, 32'h0);
    tbl[7]  = mk(32'h8000_0020, 0, D4, 1, 0, 1, 0, 32'h8000_0120);
    tbl[8]  = mk(32'h8000_0020, 0, D5, 0, 0, 1, 0, 32'h8000_002C);
    tbl[9]  = mk(32'h8000_0020, 0, D5, 1, 0, 0, 0, 32'h0);
    tbl[10] = mk(32'h8000_0030, 2, D6, 0, 1, 0, 0, 32'h0);
    tbl[11] = mk(32'h8000_0030, 1, D7, 0, 0, 0, 0, 32'h0);
    tbl[12] = mk(32'h8000_0020, 0, D8, 0, 0, 0, 0, 32'h0);
    tbl[13] = mk(32'h8000_0030, 0, D7, 1, 0, 0, 0, 32'h0);
    tbl[14] = mk(32'h8000_0030, 0, D9, 0, 0, 0, 1, 32'h8000_0038);
    tbl[15] = mk(32'h8000_0030, 0, D9, 1, 0, 0, 0, 32'h0);

    RST = 1'b1;
    core_req = 1'b0; core_addr = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    inv_valid = 1'b0; inv_addr = '0; flush = 1'b0;
    b_req = 1'b0; b_addr = '0; b_ack = 1'b0; b_mrdata = '0;
    step();
    step();
    RST = 1'b0;
    chk("rst_core_valid", core_valid, 1'b0);
    chk("rst_core_rdata", core_rdata, 128'h0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_hit_cnt", hit_cnt, 32'h0);
    chk("rst_miss_cnt", miss_cnt, 32'h0);
    step();

    for (int i = 0; i < 16; i++) run_vec(tbl[i]);

    // Back-to-back hits: request held through core_valid
    exp_q.push_back(D8);
    exp_q.push_back(D9);
    core_req  = 1'b1;
    core_addr = 32'h8000_0020;
    step();
    chk("b2b_first", core_valid, 1'b1);
    core_addr = 32'h8000_0030;
    step();
    core_req = 1'b0;
    chk("b2b_second", core_valid, 1'b1);
    m_hit += 2;
    chk("b2b_hit_cnt", hit_cnt, m_hit);
    chk("b2b_no_memreq", mem_req, 1'b0);
    step();

    // Reset while a refill is outstanding
    core_req  = 1'b1;
    core_addr = 32'h8000_0050;
    step();
    core_req = 1'b0;
    chk("rmiss_memreq", mem_req, 1'b1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rmiss_memreq_drop", mem_req, 1'b0);
    chk("rmiss_miss_cnt", miss_cnt, 32'h0);
    m_hit  = 0;
    m_miss = 0;
    mem_ack   = 1'b1;
    mem_rdata = D6;
    step();
    mem_ack = 1'b0;
    chk("late_ack_novalid", core_valid, 1'b0);
    step();
    run_vec(mk(32'h8000_0050, 1, D1, 0, 0, 0, 0, 32'h0));
    run_vec(mk(32'h8000_0020, 0, D2, 0, 0, 0, 0, 32'h0));
    run_vec(mk(32'h8000_0050, 0, D1, 1, 0, 0, 0, 32'h0));

    // Uncached instance: identical requests both go to memory
    for (int k = 0; k < 2; k++) begin
      b_req  = 1'b1;
      b_addr = 32'h8000_0010;
      step();
      chk("unc_memreq", b_mem_req, 1'b1);
      chk("unc_memaddr", b_mem_addr, 32'h8000_0010);
      b_ack    = 1'b1;
      b_mrdata = (k == 0) ? D0 : D4;
      step();
      b_ack = 1'b0;
      b_req = 1'b0;
      chk("unc_valid", b_valid, 1'b1);
      chk("unc_rdata", b_rdata, (k == 0) ? D0 : D4);
      step();
    end
    chk("unc_hit_cnt", b_hit, 32'h0);
    chk("unc_miss_cnt", b_miss, 32'd2);

    step();
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
